// File: rtl/pito_pkg.sv
// rtl/pito_pkg.sv - shared types and widths for the pito data-memory path
package pito_pkg;

    localparam int PITO_ADDR_W = 12;
    localparam int PITO_DATA_W = 32;
    localparam int PITO_BE_W   = PITO_DATA_W / 8;

    typedef enum logic [0:0] {
        RR        = 1'b0,
        HOST_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [PITO_ADDR_W-1:0] addr;
        logic [PITO_DATA_W-1:0] wdata;
        logic [PITO_BE_W-1:0]   be;
    } dmem_req_t;

endpackage

// File: rtl/pito_rr_arb2.sv
// rtl/pito_rr_arb2.sv - two-way round-robin picker with requester-1 priority override
module pito_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic prio1,
    input  logic set_last1,
    output logic gnt0,
    output logic gnt1
);

    logic last1_q;

    // Pick a winner: override favours requester 1, a tie goes to the one not served last
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (prio1) begin
            gnt1 = req1;
            gnt0 = req0 & ~req1;
        end else if (req0 && req1) begin
            gnt0 = last1_q;
            gnt1 = ~last1_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    // Remember who was served last; reset and lock exit hand the next tie to requester 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last1_q <= 1'b1;
        end else if (set_last1) begin
            last1_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last1_q <= gnt1;
        end
    end

endmodule

// File: rtl/pito_dmem_arbiter.sv
// rtl/pito_dmem_arbiter.sv - shares dmem between core and host with round-robin and host burst lock
module pito_dmem_arbiter
    import pito_pkg::*;
#(
    parameter int ADDR_W    = PITO_ADDR_W,
    parameter int DATA_W    = PITO_DATA_W,
    parameter int BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_be,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic [DATA_W/8-1:0] host_be,
    input  logic                host_lock,
    output logic                host_gnt,
    output logic                host_rvalid,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [7:0]          burst_cnt
);

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    arb_state_e state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] burst_inc;
    logic       set_last;
    logic       host_prio;
    logic       rd_pend_q;
    logic       rd_owner_q;
    dmem_req_t  sel_req;

    // The lock only overrides round-robin while the host still asks for it
    assign host_prio = (state_q == HOST_LOCK) && host_lock;
    assign burst_inc = burst_cnt_q + 8'd1;

    pito_rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (core_req),
        .req1     (host_req),
        .prio1    (host_prio),
        .set_last1(set_last),
        .gnt0     (core_gnt),
        .gnt1     (host_gnt)
    );

    // Lock FSM: enter on a locked host grant, leave on lock drop or when the burst is used up
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        set_last    = 1'b0;
        case (state_q)
            RR: begin
                if (host_gnt && host_lock) begin
                    if (BURST_LIM == 8'd1) begin
                        set_last = 1'b1;
                    end else begin
                        state_d     = HOST_LOCK;
                        burst_cnt_d = 8'd1;
                    end
                end
            end
            HOST_LOCK: begin
                if (!host_lock) begin
                    state_d     = RR;
                    burst_cnt_d = 8'd0;
                    set_last    = 1'b1;
                end else if (host_gnt) begin
                    if (burst_inc == BURST_LIM) begin
                        state_d     = RR;
                        burst_cnt_d = 8'd0;
                        set_last    = 1'b1;
                    end else begin
                        burst_cnt_d = burst_inc;
                    end
                end
            end
            default: begin
                state_d     = RR;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // Lock state and burst counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RR;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Route the granted payload to the memory port; all zero when nobody is granted
    always_comb begin
        sel_req = '0;
        if (host_gnt) begin
            sel_req = '{we: host_we, addr: host_addr, wdata: host_wdata, be: host_be};
        end else if (core_gnt) begin
            sel_req = '{we: core_we, addr: core_addr, wdata: core_wdata, be: core_be};
        end
    end

    assign mem_en    = core_gnt | host_gnt;
    assign mem_we    = sel_req.we;
    assign mem_addr  = sel_req.addr;
    assign mem_wdata = sel_req.wdata;
    assign mem_be    = sel_req.be;
    assign burst_cnt = burst_cnt_q;

    // Record which requester owns the read data returning next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= mem_en & ~sel_req.we;
            rd_owner_q <= host_gnt;
        end
    end

    assign core_rvalid = rd_pend_q & ~rd_owner_q;
    assign host_rvalid = rd_pend_q & rd_owner_q;
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: doc/pito_dmem_arbiter.md
# pito_dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the rv32 core load/store port and the host/debug port used by the testbench to preload and inspect memory. It grants one access per cycle using round-robin, with an optional bounded host burst lock. It routes each 1-cycle-latency read response back to the requester that issued it. It sits between `rv32_core`/`pito_interface` and the dmem macro.

## Interface
- `ADDR_W`, 12: word-address width of dmem.
- `DATA_W`, 32: data width.
- `BURST_MAX`, 8: maximum consecutive grants to a locked host; range 1..255.
- `clk  in  1`: sole clock.
- `rst_n  in  1`: synchronous reset, active-low.
- `core_req  in  1`, `core_we  in  1`, `core_addr  in  ADDR_W`, `core_wdata  in  DATA_W`, `core_be  in  DATA_W/8`: core request.
- `core_gnt  out  1`: core request accepted this cycle.
- `core_rvalid  out  1`, `core_rdata  out  DATA_W`: core read response.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_be`: host request, same widths as the core request.
- `host_lock  in  1`: host asks for exclusive consecutive grants.
- `host_gnt  out  1`, `host_rvalid  out  1`, `host_rdata  out  DATA_W`: host handshake and response.
- `mem_en  out  1`, `mem_we  out  1`, `mem_addr  out  ADDR_W`, `mem_wdata  out  DATA_W`, `mem_be  out  DATA_W/8`: dmem port.
- `mem_rdata  in  DATA_W`: valid one cycle after `mem_en && !mem_we`.
- `burst_cnt  out  8`: grants consumed in the current host lock.

## Operation
- Request/grant: a requester holds `*_req` and its payload stable until it sees `*_gnt`. A transfer occurs on any cycle with `req && gnt`.
- Grant is combinational from the requests and registered state. At most one `*_gnt` is high per cycle.
- The granted request drives `mem_*` in the same cycle. `mem_en` is the OR of both grants. When idle, `mem_*` are zero.
- States: `RR`, `HOST_LOCK`.
- In `RR`:
  - Only one requester active: that requester is granted.
  - Both active: grant the one not granted last, tracked by `last_host`.
  - `last_host` resets to 1, so the core wins the first tie.
- Entering `HOST_LOCK`: `RR -> HOST_LOCK` when the host is granted with `host_lock=1`. That grant counts as grant 1, so `burst_cnt` becomes 1.
- In `HOST_LOCK`:
  - The host has absolute priority; the core is not granted while `host_req=1`.
  - If `host_req=0`, the core is granted (no idle cycles wasted), and the lock persists.
  - Each host grant increments `burst_cnt`.
- Leaving `HOST_LOCK`, to `RR` with `burst_cnt` cleared and `last_host=1`, when either:
  - `host_lock` drops, or
  - a host grant makes `burst_cnt==BURST_MAX`.
- Response routing:
  - A 1-bit `rd_owner` and a `rd_pend` flag are registered on each granted read.
  - Next cycle, the owner's `*_rvalid=1` and its `*_rdata=mem_rdata`. The other requester sees rdata=0 and rvalid=0.
  - Writes produce no rvalid.
- Back-to-back reads from alternating requesters are fully pipelined at one access per cycle.
- A grant with `*_be==0` is still passed to memory unchanged; the arbiter does not filter.

## Timing
- Reset values: all `*_gnt`, `*_rvalid`, and `mem_*` are 0; all `*_rdata` are 0; `burst_cnt` is 0; state is `RR`; `rd_pend` is 0; `last_host` is 1.
- Grant latency is 0 cycles from `req` when uncontended. Read data latency is 1 cycle after grant.
- Worst-case core wait is `BURST_MAX` cycles under a continuous host lock; in `RR` it is 1 cycle.
- Reset asserted mid-operation: a pending read response is dropped (no rvalid after reset), and a lock is cancelled.
- `host_lock` rising without a host grant has no effect until the host is granted.
- `BURST_MAX=1`: a lock grants exactly once, and the state returns to `RR` on the same clock edge.

## Structure
- The shared package `pito_pkg` holds the `arb_state_e` enum (`RR`, `HOST_LOCK`) and the `dmem_req_t` struct (we, addr, wdata, be).
- The `dmem_req_t` width is derived from `ADDR_W`/`DATA_W` constants already in `pito_pkg`.
- One natural sub-module is `pito_rr_arb2`: a 2-way round-robin picker with a `last` register and a priority-override input. The lock FSM, burst counter, and response router stay in the top.

## Test plan
- Reset, then core-only read at addr 0x010 with mem returning 0xDEADBEEF -> `core_gnt` the same cycle, `core_rvalid`=1 with `core_rdata`=0xDEADBEEF next cycle, `host_rvalid`=0.
- Both requesters hold continuous reads for 6 cycles -> grants alternate core, host, core, host, …; each rvalid arrives at its owner exactly 1 cycle after its grant.
- `BURST_MAX=4`, host_lock=1, host and core both requesting -> host granted 4 consecutive cycles (`burst_cnt` 1..4), then the core is granted, then alternation resumes.
- In `HOST_LOCK`, host drops `host_req` for 1 cycle while core requests -> core granted that cycle, `burst_cnt` unchanged, lock still active.
- Host read granted, `rst_n`=0 on the next edge -> no rvalid, all outputs 0, state `RR`, and the first tie after reset goes to the core.
- Host write at 0x3FF with be=4'b0011 -> `mem_we`=1, addr 0x3FF, be 0011 in the grant cycle; no rvalid on either side.
